shift_accumulator: RTL and testbench
====================================

SHIFT_ACCUMULATOR -- requirements
Module: shift_accumulator

Interface
REQ-001 Parameter NUM_CH, default 4: number of encoder channels per slice.
REQ-002 Parameter ENC_W, default 7: width of each encoder output.
REQ-003 Parameter CELL_BITS, default 2: weight step between adjacent channels; channel c shifted left by CELL_BITS*(NUM_CH-1-c).
REQ-004 Parameter SLICE_BITS, default 2: weight step between successive input slices.
REQ-005 Parameter NUM_SLICES, default 4: slices accumulated per result.
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 start_i  input  1  begin a new accumulation.
REQ-009 clear_i  input  1  synchronous abort to IDLE.
REQ-010 encoder_output_i  input  [0:NUM_CH-1][ENC_W]  per-channel encoder values for the current slice.
REQ-011 slice_valid_i  input  1  encoder_output_i holds a valid slice.
REQ-012 slice_ready_o  output  1  block accepts a slice this cycle.
REQ-013 slice_idx_o  output  clog2(NUM_SLICES)  index of the next slice to be accepted.
REQ-014 acc_o  output  ACC_W  accumulated result.
REQ-015 result_valid_o  output  1  acc_o final.
REQ-016 result_ready_i  input  1  consumer takes the result.

Function
REQ-017 SUM_W = ENC_W+CELL_BITS*(NUM_CH-1)+1 (default 14); ACC_W = SUM_W+SLICE_BITS*(NUM_SLICES-1) (default 20).
REQ-018 Slice sum = unsigned sum over channels of the shifted values, SUM_W bits, combinational, no truncation.
REQ-019 FSM states IDLE, ACCUM, DONE.
REQ-020 IDLE: slice_ready_o=0, result_valid_o=0; start_i -> acc=0, slice index=0, next state ACCUM.
REQ-021 ACCUM: slice_ready_o=1; on slice_valid_i: acc += slice_sum << (k*SLICE_BITS), k = current index; index increments.
REQ-022 Acceptance of slice NUM_SLICES-1 -> DONE next cycle, index wraps to 0.
REQ-023 slice_valid_i outside ACCUM is ignored; no acc change.
REQ-024 DONE: result_valid_o=1, acc_o stable until result_ready_i; result_ready_i -> IDLE; result_ready_i with start_i in the same cycle -> ACCUM with acc cleared (back-to-back).
REQ-025 start_i in ACCUM, or in DONE without result_ready_i, is ignored.
REQ-026 clear_i in any state -> IDLE next cycle, acc=0, index=0; clear_i wins over start_i, slice_valid_i and result_ready_i.
REQ-027 acc_o is driven from the register in all states; latency from last slice acceptance to result_valid_o is 1 cycle.

Reset
REQ-028 rst_i -> IDLE, acc_o=0, slice_idx_o=0, slice_ready_o=0, result_valid_o=0 on the next edge; rst_i overrides all inputs, including mid-ACCUM.

Configuration
REQ-029 Macro SHIFT_ACC_SIGNED_EN defined: the slice with index NUM_SLICES-1 carries negative weight (shifted slice sum subtracted); acc_o is two's complement and ACC_W grows by 1 (default 21).
REQ-030 Macro absent: all slices are added and acc_o is unsigned ACC_W.

Structure
REQ-031 Package shift_acc_pkg: FSM state enum, width functions for SUM_W and ACC_W.
REQ-032 Sub-module shift_sum: the combinational weighted channel sum, parametrised by NUM_CH, ENC_W and CELL_BITS.
REQ-033 An elaboration-time check rejects CELL_BITS<2, SLICE_BITS<2 and NUM_SLICES<2.

Verification
REQ-034 Defaults, all channels=1, 4 slices back-to-back -> slice sum 85, acc_o=7225, result_valid_o 1 cycle after the 4th accept.
REQ-035 All channels=127, 4 slices -> acc_o=917575, no overflow.
REQ-036 Signed build, slice sums 85,0,0,85 -> acc_o=-5355 (two's complement, 21 bits).
REQ-037 clear_i asserted with slice_valid_i after 2 slices -> IDLE, acc_o=0, slice_idx_o=0; a subsequent start_i runs a full 4-slice pass correctly.
REQ-038 DONE with result_ready_i low for 5 cycles -> acc_o stable; result_ready_i+start_i together -> ACCUM with acc 0.
REQ-039 rst_i mid-ACCUM at slice 2 -> all outputs zero next cycle; slice_valid_i while IDLE has no effect.

Source files
------------

// File: rtl/shift_acc_pkg.sv
// rtl/shift_acc_pkg.sv - FSM state type and width helpers for shift_accumulator
// SHIFT_ACC_SIGNED_EN adds one sign bit to the accumulator width.
package shift_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

`ifdef SHIFT_ACC_SIGNED_EN
  localparam int SIGN_BITS = 1;
`else
  localparam int SIGN_BITS = 0;
`endif

  function automatic int sum_w(input int num_ch, input int enc_w, input int cell_bits);
    return enc_w + cell_bits * (num_ch - 1) + 1;
  endfunction

  function automatic int acc_w(input int num_ch, input int enc_w, input int cell_bits,
                               input int slice_bits, input int num_slices);
    return sum_w(num_ch, enc_w, cell_bits) + slice_bits * (num_slices - 1) + SIGN_BITS;
  endfunction

endpackage

// File: rtl/shift_sum.sv
// rtl/shift_sum.sv - combinational weighted sum of one slice of encoder channels
// Channel 0 carries the highest weight; the result is sized so it never truncates.
module shift_sum
  import shift_acc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ENC_W     = 7,
  parameter int CELL_BITS = 2
) (
  input  logic [0:NUM_CH-1][ENC_W-1:0]                  enc,
  output logic [sum_w(NUM_CH, ENC_W, CELL_BITS)-1:0]    sum
);

  localparam int SUM_W = sum_w(NUM_CH, ENC_W, CELL_BITS);

  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = sum + (SUM_W'(enc[c]) << (CELL_BITS * (NUM_CH - 1 - c)));
    end
  end

endmodule

// File: rtl/shift_accumulator.sv
// rtl/shift_accumulator.sv - bit-sliced shift-and-accumulate of encoder slice sums
// SHIFT_ACC_SIGNED_EN: the last slice is subtracted and acc_o is two's complement.
module shift_accumulator
  import shift_acc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ENC_W      = 7,
  parameter int CELL_BITS  = 2,
  parameter int SLICE_BITS = 2,
  parameter int NUM_SLICES = 4
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
  input  logic                                                          start_i,
  input  logic                                                          clear_i,
  input  logic [0:NUM_CH-1][ENC_W-1:0]                                  encoder_output_i,
  input  logic                                                          slice_valid_i,
  output logic                                                          slice_ready_o,
  output logic [$clog2(NUM_SLICES)-1:0]                                 slice_idx_o,
  output logic [acc_w(NUM_CH, ENC_W, CELL_BITS, SLICE_BITS, NUM_SLICES)-1:0] acc_o,
  output logic                                                          result_valid_o,
  input  logic                                                          result_ready_i
);

  localparam int SUM_W = sum_w(NUM_CH, ENC_W, CELL_BITS);
  localparam int ACC_W = acc_w(NUM_CH, ENC_W, CELL_BITS, SLICE_BITS, NUM_SLICES);
  localparam int IDX_W = $clog2(NUM_SLICES);

  if (CELL_BITS < 2 || SLICE_BITS < 2 || NUM_SLICES < 2) begin : g_bad_params
    $error("shift_accumulator: CELL_BITS, SLICE_BITS and NUM_SLICES must each be >= 2");
  end

  state_t             state;
  logic [SUM_W-1:0]   slice_sum;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   next_acc;
  logic               last;

  shift_sum #(
    .NUM_CH    (NUM_CH),
    .ENC_W     (ENC_W),
    .CELL_BITS (CELL_BITS)
  ) u_shift_sum (
    .enc (encoder_output_i),
    .sum (slice_sum)
  );

  assign last = (slice_idx_o == IDX_W'(NUM_SLICES - 1));

  always_comb begin
    term     = ACC_W'(slice_sum) << (SLICE_BITS * int'(slice_idx_o));
    next_acc = acc_o + term;
`ifdef SHIFT_ACC_SIGNED_EN
    // The most significant slice is the sign slice.
    if (last) begin
      next_acc = acc_o - term;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state          <= ST_IDLE;
      acc_o          <= '0;
      slice_idx_o    <= '0;
      slice_ready_o  <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state         <= ST_ACCUM;
            acc_o         <= '0;
            slice_idx_o   <= '0;
            slice_ready_o <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (slice_valid_i) begin
            acc_o <= next_acc;
            if (last) begin
              state          <= ST_DONE;
              slice_idx_o    <= '0;
              slice_ready_o  <= 1'b0;
              result_valid_o <= 1'b1;
            end else begin
              slice_idx_o <= slice_idx_o + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            if (start_i) begin
              state         <= ST_ACCUM;
              acc_o         <= '0;
              slice_idx_o   <= '0;
              slice_ready_o <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state          <= ST_IDLE;
          slice_ready_o  <= 1'b0;
          result_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_accumulator.sv
// tb/tb_shift_accumulator.sv - directed vector bench for shift_accumulator
// Expected values follow the SHIFT_ACC_SIGNED_EN setting of the build.
module tb_shift_accumulator;

`ifdef SHIFT_ACC_SIGNED_EN
  localparam int ACC_W = 21;
`else
  localparam int ACC_W = 20;
`endif

  typedef struct {
    logic [0:3][0:3][6:0] slices;
    logic [20:0]          exp_acc;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 clear = 1'b0;
  logic [0:3][6:0]      enc = '0;
  logic                 slice_valid = 1'b0;
  logic                 slice_ready;
  logic [1:0]           slice_idx;
  logic [ACC_W-1:0]     acc;
  logic                 result_valid;
  logic                 result_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  vec_t vecs[4];
  logic [ACC_W-1:0] held;

  always #5 clk = ~clk;

  shift_accumulator dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .clear_i          (clear),
    .encoder_output_i (enc),
    .slice_valid_i    (slice_valid),
    .slice_ready_o    (slice_ready),
    .slice_idx_o      (slice_idx),
    .acc_o            (acc),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("accum_ready", 32'(slice_ready), 32'd1);
  endtask

  task automatic feed(input int n, input logic [0:3][0:3][6:0] sl);
    for (int k = 0; k < n; k++) begin
      chk("slice_idx", 32'(slice_idx), 32'(k));
      enc = sl[k];
      slice_valid = 1'b1;
      step();
    end
    slice_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [20:0] exp);
    chk({name, "_valid"}, 32'(result_valid), 32'd1);
    chk({name, "_ready_low"}, 32'(slice_ready), 32'd0);
    chk({name, "_acc"}, 32'(acc), 32'(exp[ACC_W-1:0]));
  endtask

  initial begin
    vecs[0].slices = {4{{7'd1, 7'd1, 7'd1, 7'd1}}};
    vecs[0].exp_acc = 21'd7225;
    vecs[1].slices = {4{{7'd127, 7'd127, 7'd127, 7'd127}}};
    vecs[1].exp_acc = 21'd917575;
    vecs[2].slices = {{7'd1, 7'd1, 7'd1, 7'd1}, {7'd0, 7'd0, 7'd0, 7'd0},
                      {7'd0, 7'd0, 7'd0, 7'd0}, {7'd1, 7'd1, 7'd1, 7'd1}};
    vecs[3].slices = {{7'd0, 7'd0, 7'd0, 7'd1}, {7'd0, 7'd0, 7'd3, 7'd0},
                      {7'd0, 7'd5, 7'd0, 7'd0}, {7'd2, 7'd0, 7'd0, 7'd0}};
`ifdef SHIFT_ACC_SIGNED_EN
    vecs[2].exp_acc = 21'h200000 - 21'd5355;
    vecs[3].exp_acc = 21'h200000 - 21'd6863;
`else
    vecs[2].exp_acc = 21'd5525;
    vecs[3].exp_acc = 21'd9521;
`endif

    step();
    step();
    rst = 1'b0;
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_idx", 32'(slice_idx), 32'd0);
    chk("rst_ready", 32'(slice_ready), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);

    // Slices offered while idle must not touch the accumulator.
    enc = {7'd127, 7'd127, 7'd127, 7'd127};
    slice_valid = 1'b1;
    step();
    step();
    slice_valid = 1'b0;
    chk("idle_ignore_acc", 32'(acc), 32'd0);
    chk("idle_ignore_ready", 32'(slice_ready), 32'd0);

    for (int v = 0; v < 4; v++) begin
      start_pass();
      feed(4, vecs[v].slices);
      check_result($sformatf("vec%0d", v), vecs[v].exp_acc);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("release_valid", 32'(result_valid), 32'd0);
      chk("release_acc", 32'(acc), 32'(vecs[v].exp_acc[ACC_W-1:0]));
    end

    // Clear mid-pass wins over a simultaneous slice.
    start_pass();
    feed(2, vecs[1].slices);
    clear = 1'b1;
    slice_valid = 1'b1;
    step();
    clear = 1'b0;
    slice_valid = 1'b0;
    chk("clear_acc", 32'(acc), 32'd0);
    chk("clear_idx", 32'(slice_idx), 32'd0);
    chk("clear_ready", 32'(slice_ready), 32'd0);
    start_pass();
    feed(4, vecs[0].slices);
    check_result("after_clear", vecs[0].exp_acc);

    // Result held while the consumer stalls; start alone is ignored in DONE.
    held = acc;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_acc", 32'(acc), 32'(held));
    end
    start = 1'b0;
    result_ready = 1'b1;
    start = 1'b1;
    step();
    result_ready = 1'b0;
    start = 1'b0;
    chk("b2b_ready", 32'(slice_ready), 32'd1);
    chk("b2b_acc", 32'(acc), 32'd0);
    chk("b2b_valid", 32'(result_valid), 32'd0);
    feed(4, vecs[1].slices);
    check_result("b2b", vecs[1].exp_acc);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Reset in the middle of accumulation.
    start_pass();
    feed(2, vecs[0].slices);
    rst = 1'b1;
    slice_valid = 1'b1;
    step();
    rst = 1'b0;
    slice_valid = 1'b0;
    chk("midrst_acc", 32'(acc), 32'd0);
    chk("midrst_idx", 32'(slice_idx), 32'd0);
    chk("midrst_ready", 32'(slice_ready), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
